// File: rtl/motion_pixel_word_writer.sv
// Packs an 8-bit pixel stream into little-endian 32-bit words and writes them
// to a zero-wait-state single-port RAM, with per-frame count and sticky errors.
module motion_pixel_word_writer #(
  parameter int ADDR_W    = 13,
  parameter int DEPTH     = 8192,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sop,
  input  logic              in_eop,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              frame_done,
  output logic [ADDR_W:0]   frame_words,
  output logic              overflow,
  output logic              sop_restart,
  input  logic              clear_status
);

  typedef enum logic {IDLE, PACK} state_t;

  localparam logic [ADDR_W:0]   CAP      = (ADDR_W+1)'(DEPTH - BASE_ADDR);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   WORD_ONE = (ADDR_W+1)'(1);

  state_t            state_q, state_d;
  logic [31:0]       pack_q, pack_d;
  logic [3:0]        be_q, be_d;
  logic [1:0]        lane_q, lane_d;
  logic [ADDR_W:0]   word_q, word_d;

  logic              wr_d, done_d, ovf_d, rst_d;
  logic [ADDR_W-1:0] addr_d;
  logic [3:0]        wbe_d;
  logic [31:0]       data_d;
  logic [ADDR_W:0]   fw_d;

  logic              beat, start, restart, full, accept, drop, flush;
  logic [1:0]        lane_sel;
  logic [31:0]       base_pack, merged_pack;
  logic [3:0]        base_be, merged_be;
  logic [ADDR_W:0]   base_word;

  // A sop beat always opens a fresh frame, discarding any partial word.
  assign beat      = in_valid & in_ready;
  assign start     = beat & in_sop;
  assign restart   = start & (state_q == PACK);
  assign full      = (word_q == CAP);
  assign accept    = start | (beat & (state_q == PACK) & ~full);
  assign drop      = beat & ~in_sop & (state_q == PACK) & full;
  assign lane_sel  = start ? 2'd0 : lane_q;
  assign base_pack = start ? '0 : pack_q;
  assign base_be   = start ? '0 : be_q;
  assign base_word = start ? '0 : word_q;
  assign merged_be = base_be | (4'b0001 << lane_sel);
  assign flush     = accept & ((lane_sel == 2'd3) | in_eop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = in_eop ? IDLE : PACK;
      PACK:    if (beat && in_eop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    merged_pack = base_pack;
    merged_pack[{lane_sel, 3'b000} +: 8] = in_data;

    pack_d = pack_q;
    be_d   = be_q;
    lane_d = lane_q;
    word_d = word_q;
    wr_d   = 1'b0;
    addr_d = '0;
    wbe_d  = '0;
    data_d = '0;
    done_d = 1'b0;
    fw_d   = frame_words;
    ovf_d  = clear_status ? 1'b0 : overflow;
    rst_d  = clear_status ? 1'b0 : sop_restart;

    if (drop)    ovf_d = 1'b1;
    if (restart) rst_d = 1'b1;

    if (flush) begin
      wr_d   = 1'b1;
      addr_d = BASE + base_word[ADDR_W-1:0];
      wbe_d  = merged_be;
      data_d = merged_pack;
      pack_d = '0;
      be_d   = '0;
      lane_d = '0;
      word_d = base_word + WORD_ONE;
    end else if (accept) begin
      pack_d = merged_pack;
      be_d   = merged_be;
      lane_d = lane_sel + 2'd1;
      word_d = base_word;
    end

    // Past capacity the eop is dropped but still closes the frame.
    if (flush && in_eop) begin
      done_d = 1'b1;
      fw_d   = base_word + WORD_ONE;
    end else if (drop && in_eop) begin
      done_d = 1'b1;
      fw_d   = word_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pack_q         <= '0;
      be_q           <= '0;
      lane_q         <= '0;
      word_q         <= '0;
      in_ready       <= 1'b0;
      mem_address    <= '0;
      mem_byteenable <= '0;
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
      mem_writedata  <= '0;
      frame_done     <= 1'b0;
      frame_words    <= '0;
      overflow       <= 1'b0;
      sop_restart    <= 1'b0;
    end else begin
      pack_q         <= pack_d;
      be_q           <= be_d;
      lane_q         <= lane_d;
      word_q         <= word_d;
      in_ready       <= enable;
      mem_address    <= addr_d;
      mem_byteenable <= wbe_d;
      mem_chipselect <= wr_d;
      mem_write      <= wr_d;
      mem_writedata  <= data_d;
      frame_done     <= done_d;
      frame_words    <= fw_d;
      overflow       <= ovf_d;
      sop_restart    <= rst_d;
    end
  end

endmodule

// File: tb/tb_motion_pixel_word_writer.sv
// Bench for motion_pixel_word_writer: directed frames plus randomized gaps,
// checked against a frame-level model of the expected RAM writes.
module tb_motion_pixel_word_writer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_sop = 1'b0;
  logic        in_eop = 1'b0;
  logic        clear_status = 1'b0;
  logic        sel = 1'b0;
  logic        valid_a, valid_b;

  logic        in_ready_a, mem_chipselect_a, mem_write_a, frame_done_a, overflow_a, sop_restart_a;
  logic [12:0] mem_address_a;
  logic [3:0]  mem_byteenable_a;
  logic [31:0] mem_writedata_a;
  logic [13:0] frame_words_a;
  logic        in_ready_b, mem_chipselect_b, mem_write_b, frame_done_b, overflow_b, sop_restart_b;
  logic [12:0] mem_address_b;
  logic [3:0]  mem_byteenable_b;
  logic [31:0] mem_writedata_b;
  logic [13:0] frame_words_b;

  int checks = 0;
  int failures = 0;

  assign valid_a = in_valid & ~sel;
  assign valid_b = in_valid & sel;

  always #5 clk = ~clk;

  motion_pixel_word_writer #(.ADDR_W(13), .DEPTH(8192), .BASE_ADDR(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .enable(enable), .in_data(in_data), .in_valid(valid_a),
    .in_ready(in_ready_a), .in_sop(in_sop), .in_eop(in_eop), .mem_address(mem_address_a),
    .mem_byteenable(mem_byteenable_a), .mem_chipselect(mem_chipselect_a), .mem_write(mem_write_a),
    .mem_writedata(mem_writedata_a), .frame_done(frame_done_a), .frame_words(frame_words_a),
    .overflow(overflow_a), .sop_restart(sop_restart_a), .clear_status(clear_status));

  motion_pixel_word_writer #(.ADDR_W(13), .DEPTH(8192), .BASE_ADDR(8190)) dut_b (
    .clk(clk), .reset_n(reset_n), .enable(enable), .in_data(in_data), .in_valid(valid_b),
    .in_ready(in_ready_b), .in_sop(in_sop), .in_eop(in_eop), .mem_address(mem_address_b),
    .mem_byteenable(mem_byteenable_b), .mem_chipselect(mem_chipselect_b), .mem_write(mem_write_b),
    .mem_writedata(mem_writedata_b), .frame_done(frame_done_b), .frame_words(frame_words_b),
    .overflow(overflow_b), .sop_restart(sop_restart_b), .clear_status(clear_status));

  // Reference model state: one open frame at a time, sticky flags per instance.
  int unsigned  base_of [2] = '{0, 8190};
  int unsigned  cap_of  [2] = '{8192, 2};
  bit           m_inf = 1'b0;
  logic [7:0]   m_pix[$];
  bit           m_ovf [2] = '{1'b0, 1'b0};
  bit           m_rst [2] = '{1'b0, 1'b0};
  logic [48:0]  expq0[$], expq1[$], capq0[$], capq1[$];
  int           expd0[$], expd1[$], donq0[$], donq1[$];
  bit           pbeat_a = 1'b0, pbeat_b = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_beat(input logic [7:0] d, input bit sop, input bit eop);
    int unsigned len, w, lanes, fw;
    logic [31:0] data;
    logic [3:0]  be;
    logic [12:0] addr;
    if (sop) begin
      if (m_inf) m_rst[sel] = 1'b1;
      m_pix.delete();
      m_inf = 1'b1;
    end else if (!m_inf) begin
      return;
    end
    m_pix.push_back(d);
    len = m_pix.size();
    w   = (len - 1) / 4;
    if (w >= cap_of[sel]) begin
      m_ovf[sel] = 1'b1;
    end else if ((len % 4 == 0) || eop) begin
      lanes = len - 4 * w;
      data  = '0;
      for (int unsigned k = 0; k < lanes; k++) data = data | (32'(m_pix[4*w+k]) << (8 * k));
      be   = 4'((1 << lanes) - 1);
      addr = 13'(base_of[sel] + w);
      if (sel) expq1.push_back({addr, be, data});
      else     expq0.push_back({addr, be, data});
    end
    if (eop) begin
      fw = (len + 3) / 4;
      if (fw > cap_of[sel]) fw = cap_of[sel];
      if (sel) expd1.push_back(int'(fw));
      else     expd0.push_back(int'(fw));
      m_inf = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (mem_write_a || mem_chipselect_a) begin
      chk("cs_with_write_a", mem_chipselect_a, mem_write_a);
      chk("write_after_beat_a", pbeat_a, 1'b1);
      if (mem_write_a) capq0.push_back({mem_address_a, mem_byteenable_a, mem_writedata_a});
    end
    if (mem_write_b || mem_chipselect_b) begin
      chk("cs_with_write_b", mem_chipselect_b, mem_write_b);
      chk("write_after_beat_b", pbeat_b, 1'b1);
      if (mem_write_b) capq1.push_back({mem_address_b, mem_byteenable_b, mem_writedata_b});
    end
    if (frame_done_a) donq0.push_back(int'(frame_words_a));
    if (frame_done_b) donq1.push_back(int'(frame_words_b));
    pbeat_a = valid_a && in_ready_a && reset_n;
    pbeat_b = valid_b && in_ready_b && reset_n;
  end

  task automatic send(input logic [7:0] d, input bit sop, input bit eop, input bit rnd);
    int guard = 0;
    if (rnd) begin
      repeat ($urandom_range(0, 2)) begin
        enable = ($urandom_range(0, 3) != 0);
        @(posedge clk); #1;
      end
    end
    in_data = d; in_sop = sop; in_eop = eop; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (sel ? in_ready_b : in_ready_a) break;
      @(posedge clk); #1;
      guard++;
      if (rnd) enable = ($urandom_range(0, 1) == 1) || (guard > 6);
      if (guard > 100) begin
        checks++; failures++;
        $error("FAIL in_ready_timeout observed=0 expected=1");
        in_valid = 1'b0;
        return;
      end
    end
    model_beat(d, sop, eop);
    @(posedge clk); #1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic settle_check(input string tag);
    logic [48:0] cq[$], eq[$];
    int          cd[$], ed[$];
    repeat (3) @(posedge clk);
    #1;
    if (sel) begin cq = capq1; eq = expq1; cd = donq1; ed = expd1; end
    else     begin cq = capq0; eq = expq0; cd = donq0; ed = expd0; end
    chk({tag, ".nwrites"}, cq.size(), eq.size());
    for (int i = 0; i < cq.size() && i < eq.size(); i++) chk({tag, ".write"}, cq[i], eq[i]);
    chk({tag, ".ndone"}, cd.size(), ed.size());
    for (int i = 0; i < cd.size() && i < ed.size(); i++) chk({tag, ".frame_words"}, cd[i], ed[i]);
    chk({tag, ".overflow"}, sel ? overflow_b : overflow_a, m_ovf[sel]);
    chk({tag, ".sop_restart"}, sel ? sop_restart_b : sop_restart_a, m_rst[sel]);
    capq0.delete(); capq1.delete(); expq0.delete(); expq1.delete();
    donq0.delete(); donq1.delete(); expd0.delete(); expd1.delete();
  endtask

  task automatic do_clear(input string tag);
    clear_status = 1'b1;
    @(posedge clk); #1;
    clear_status = 1'b0;
    m_ovf = '{1'b0, 1'b0};
    m_rst = '{1'b0, 1'b0};
    chk({tag, ".overflow"}, sel ? overflow_b : overflow_a, m_ovf[sel]);
    chk({tag, ".sop_restart"}, sel ? sop_restart_b : sop_restart_a, m_rst[sel]);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_bus_a", {mem_address_a, mem_byteenable_a, mem_chipselect_a, mem_write_a, mem_writedata_a}, '0);
    chk("reset_status_a", {in_ready_a, frame_done_a, frame_words_a, overflow_a, sop_restart_a}, '0);
    chk("reset_bus_b", {mem_address_b, mem_byteenable_b, mem_chipselect_b, mem_write_b, mem_writedata_b}, '0);
    chk("reset_status_b", {in_ready_b, frame_done_b, frame_words_b, overflow_b, sop_restart_b}, '0);
    reset_n = 1'b1;
    enable  = 1'b1;
    @(posedge clk); #1;

    for (int i = 1; i <= 8; i++) send(8'(i), i == 1, i == 8, 1'b0);
    settle_check("frame8");

    for (int i = 0; i < 5; i++) send(8'(8'hA0 + i), i == 0, i == 4, 1'b0);
    settle_check("frame5");

    send(8'h55, 1'b1, 1'b1, 1'b0);
    settle_check("single");

    for (int i = 0; i < 6; i++) send(8'(8'h11 + i), i == 0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send(8'(8'h21 + i), i == 0, i == 3, 1'b0);
    settle_check("restart");
    do_clear("restart_clear");

    for (int i = 0; i < 64; i++) send(8'($urandom), i == 0, i == 63, 1'b1);
    enable = 1'b1;
    settle_check("random64");

    for (int i = 0; i < 4; i++) send(8'(8'hC0 + i), i == 0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("midreset_bus_a", {mem_address_a, mem_byteenable_a, mem_chipselect_a, mem_write_a, mem_writedata_a}, '0);
    chk("midreset_status_a", {in_ready_a, frame_done_a, frame_words_a, overflow_a, sop_restart_a}, '0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    m_inf = 1'b0;
    m_pix.delete();
    expq0.delete();
    m_ovf = '{1'b0, 1'b0};
    m_rst = '{1'b0, 1'b0};
    settle_check("after_reset");
    for (int i = 0; i < 3; i++) send(8'(8'hD0 + i), i == 0, i == 2, 1'b0);
    settle_check("post_reset_frame");

    sel = 1'b1;
    for (int i = 0; i < 12; i++) send(8'(8'h40 + i), i == 0, i == 11, 1'b0);
    settle_check("cap_frame");
    do_clear("cap_clear");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
